sa_host_seq: RTL and testbench
==============================

Name: sa_host_seq

Overview:
- Initiator-side sequencer for the systolic-array accelerator's 8-bit address / 32-bit write-data bus.
- Accepts a 128-element byte stream: 64 weights then 64 activations. Writes them into the array, issues start, and polls the done status bit.
- Then reads back all 64 output-buffer entries and streams them out with valid/ready backpressure.
- Sits between a DMA/test source and the accelerator top.

Parameters:
MAC_W, 19, accumulator width; result words are MAC_W+1 bits
X_W, 8, weight/activation element width
POLL_TIMEOUT, 1024, max poll cycles before err_o is set
START_GUARD, 2, idle cycles after the start write before the first status sample

Ports:
clk_i  input  1  clock
rst_i  input  1  asynchronous active-low reset
start_i  input  1  one-cycle pulse; begins a job when IDLE, ignored otherwise
busy_o  output  1  high in any state other than IDLE
done_o  output  1  one-cycle pulse after the last result handshake
err_o  output  1  sticky poll-timeout flag; cleared by the next accepted start_i
src_data_i  input  X_W  weight/activation element
src_v_i  input  1  source valid
src_rdy_o  output  1  source ready; high only in LOAD_W/LOAD_X
res_data_o  output  MAC_W+1  result word
res_idx_o  output  6  result index 0..63 (column*8+row, equal to bus offset)
res_v_o  output  1  result valid
res_rdy_i  input  1  result ready
bus_addr_o  output  8  accelerator address
bus_data_o  output  32  accelerator write data
bus_wr_vo  output  1  write strobe
bus_rdata_i  input  MAC_W+1  accelerator read data, valid one cycle after the address is presented

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0.
- Address map: 0..63 weights, 64..127 activations, 128..191 output buffer (write = clear/config, read = result), 192..255 start.
  - Status read: rdata bit0 = done, returned for any address outside 128..191 with bus_wr_vo=0.
- bus_data_o is zero-extended.
- When no write or read is being issued, bus_addr_o=8'd192 and bus_wr_vo=0 (parked status address).
- FSM:
  - IDLE: on start_i, clear err_o and counters; go to LOAD_W.
  - LOAD_W: each src_v_i&&src_rdy_o cycle drives bus_wr_vo=1, addr=cnt, data=src_data_i, same cycle (no registering). After the 64th write go to LOAD_X. Stalls while src_v_i=0; no write is issued on stall cycles.
  - LOAD_X: same, addr=64+cnt. After the 64th write go to CLR.
  - CLR: one write, addr 128, data 0. Go to START.
  - START: one write, addr 192, data 0. Load guard counter = START_GUARD. Go to WAIT.
  - WAIT: parked address; decrement the guard. At 0 go to POLL.
  - POLL: parked address. Sample bus_rdata_i[0] every cycle.
    - Bit0 = 1: go to READ.
    - Poll counter reaches POLL_TIMEOUT: set err_o, pulse done_o, go to IDLE; no results are emitted.
  - READ: issue read addr 128+ridx only when the in-flight count plus the 2-entry result FIFO occupancy is < 2. The data returning the next cycle is pushed into the FIFO with tag ridx.
    - Go to DRAIN after the 64th issue.
  - DRAIN: wait until the FIFO is empty and nothing is in flight; pulse done_o; go to IDLE.
- Result FIFO: 2 entries; res_v_o = not empty.
  - Simultaneous push and pop is allowed when full.
  - Data is never dropped; res_data_o is stable while res_v_o && !res_rdy_i.
- Read timing: the read address must be held for exactly one cycle per issue. The sample uses the registered "read issued" flag, not the current address.
- Asynchronous reset mid-job: returns to IDLE immediately, discards the FIFO, deasserts bus_wr_vo.
- start_i while busy_o=1 is ignored.

Decomposition:
- Package sa_pkg:
  - Address-region constants: ADDR_W_BASE=0, ADDR_X_BASE=64, ADDR_O_BASE=128, ADDR_START=192.
  - State enum: IDLE, LOAD_W, LOAD_X, CLR, START, WAIT, POLL, READ, DRAIN.
  - MAC_W/X_W defaults.
- One sub-module: sa_res_fifo, a 2-entry valid/ready FIFO carrying {idx, data}.

Test Plan:
- Ramp load: start_i; src supplies 0..127 with src_v_i=1 continuously. Required: 64 writes at addr 0..63 with data 0..63, then 64 writes at addr 64..127 with data 64..127, then a write to 128 (data 0), then a write to 192, all on consecutive cycles (130 writes total).
- Source stalls: src_v_i toggled 1/0 every cycle. Required: no write on stall cycles, addresses remain contiguous, 130 writes total.
- Poll: bus model asserts done 24 cycles after the start write. Required: no read at 128..191 before done; first read addr 128 follows the first cycle bit0 is seen =1.
- Backpressure: bus model returns data = 1000+offset; res_rdy_i high 1 cycle in 3. Required: 64 results with idx 0..63 and data 1000..1063 in order, none lost or duplicated, then a single done_o pulse.
- Timeout: POLL_TIMEOUT=16, bus never asserts done. Required: err_o=1 and one done_o pulse after 16 poll cycles, zero res_v_o. The next start_i clears err_o.
- Reset mid-READ: deassert rst_i after 10 results. Required: all outputs 0 immediately, state IDLE; a subsequent start_i runs a full clean job.

Source files
------------

// File: rtl/sa_pkg.sv
// sa_pkg: shared definitions for the systolic-array host sequencer.
//   - Accelerator bus address regions (weights, activations, output buffer, start).
//   - Sequencer state encoding.
//   - Default element / accumulator widths.
//   - region_addr(): builds a bus address from a region base and a 6-bit offset.
package sa_pkg;

  localparam int MAC_W_DEF = 19;
  localparam int X_W_DEF   = 8;

  localparam logic [7:0] ADDR_W_BASE = 8'd0;
  localparam logic [7:0] ADDR_X_BASE = 8'd64;
  localparam logic [7:0] ADDR_O_BASE = 8'd128;
  localparam logic [7:0] ADDR_START  = 8'd192;

  typedef enum logic [3:0] {
    IDLE,
    LOAD_W,
    LOAD_X,
    CLR,
    START,
    WAIT,
    POLL,
    READ,
    DRAIN
  } seq_state_t;

  // Every region is 64 entries on a 64-aligned base, so OR-ing the offset is exact.
  function automatic logic [7:0] region_addr(input logic [7:0] base, input logic [5:0] off);
    return base | {2'b00, off};
  endfunction

endpackage

// File: rtl/sa_res_fifo.sv
// sa_res_fifo: 2-entry valid/ready FIFO carrying {idx, data} result words.
// Ports:
//   clk_i, rst_i  clock, asynchronous active-low reset (clears occupancy only)
//   push          write push_data this cycle (caller guarantees a free slot or a pop)
//   push_data     {idx, data} word to store
//   pop_rdy       downstream ready; a pop happens when vld && pop_rdy
//   q             head entry, forced to 0 while empty
//   vld           FIFO not empty
//   count         occupancy 0..2
module sa_res_fifo
#(
  parameter int W = 26
)(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop_rdy,
  output logic [W-1:0] q,
  output logic         vld,
  output logic [1:0]   count
);

  logic [W-1:0] mem0;  // head
  logic [W-1:0] mem1;
  logic         pop;

  assign vld = (count != 2'd0);
  assign pop = vld && pop_rdy;
  // Zero while empty so the output port reads 0 out of reset; the head
  // register itself only changes on push/pop, keeping q stable under stall.
  assign q   = vld ? mem0 : '0;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    case ({push, pop})
      2'b10: begin
        if (count == 2'd0) mem0 <= push_data;
        else               mem1 <= push_data;
      end
      2'b01: mem0 <= mem1;
      2'b11: begin
        // With one entry the new word becomes the head directly; when full the
        // second entry shifts up and the new word takes its place.
        if (count == 2'd1) begin
          mem0 <= push_data;
        end else begin
          mem0 <= mem1;
          mem1 <= push_data;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/sa_host_seq.sv
// sa_host_seq: initiator-side sequencer for the systolic-array accelerator.
// Loads 64 weights and 64 activations from a byte stream onto the 8-bit
// address / 32-bit write bus, clears the output buffer, issues start, polls the
// done bit, then reads the 64 output-buffer entries and streams them out.
// Ports:
//   clk_i, rst_i        clock, asynchronous active-low reset
//   start_i             job start pulse (ignored while busy_o)
//   busy_o, done_o      job in progress / one-cycle end-of-job pulse
//   err_o               sticky poll timeout, cleared by the next accepted start
//   src_data_i/v_i/rdy_o  element stream in (weights then activations)
//   res_data_o/idx_o/v_o, res_rdy_i  result stream out, idx = bus offset
//   bus_addr_o, bus_data_o, bus_wr_vo  accelerator bus request
//   bus_rdata_i         accelerator read data, one cycle after the address
module sa_host_seq
  import sa_pkg::*;
#(
  parameter int MAC_W        = MAC_W_DEF,
  parameter int X_W          = X_W_DEF,
  parameter int POLL_TIMEOUT = 1024,
  parameter int START_GUARD  = 2
)(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  input  logic [X_W-1:0]   src_data_i,
  input  logic             src_v_i,
  output logic             src_rdy_o,
  output logic [MAC_W:0]   res_data_o,
  output logic [5:0]       res_idx_o,
  output logic             res_v_o,
  input  logic             res_rdy_i,
  output logic [7:0]       bus_addr_o,
  output logic [31:0]      bus_data_o,
  output logic             bus_wr_vo,
  input  logic [MAC_W:0]   bus_rdata_i
);

  localparam int RW = MAC_W + 1;
  localparam int FW = 6 + RW;
  localparam int PW = $clog2(POLL_TIMEOUT + 1);

  seq_state_t    state;
  logic [5:0]    cnt;
  logic [5:0]    ridx;
  logic [7:0]    guard;
  logic [PW-1:0] poll_cnt;

  logic          src_hs;
  logic          rd_issue;
  logic [1:0]    occ;
  logic [7:0]    addr_c;

  logic          rd_vld_p1;
  logic [5:0]    rd_idx_p1;

  logic [FW-1:0] fifo_q;
  logic          fifo_vld;
  logic [1:0]    fifo_cnt;

  assign src_rdy_o = (state == LOAD_W) || (state == LOAD_X);
  assign src_hs    = src_v_i && src_rdy_o;

  // Reads in flight plus buffered results may never exceed the FIFO depth,
  // so a returning word always finds a free slot.
  assign occ      = fifo_cnt + {1'b0, rd_vld_p1};
  assign rd_issue = (state == READ) && (occ < 2'd2);

  always_comb begin
    addr_c     = ADDR_START;
    bus_wr_vo  = 1'b0;
    bus_data_o = '0;
    case (state)
      LOAD_W: begin
        if (src_hs) begin
          bus_wr_vo  = 1'b1;
          addr_c     = region_addr(ADDR_W_BASE, cnt);
          bus_data_o = 32'(src_data_i);
        end
      end
      LOAD_X: begin
        if (src_hs) begin
          bus_wr_vo  = 1'b1;
          addr_c     = region_addr(ADDR_X_BASE, cnt);
          bus_data_o = 32'(src_data_i);
        end
      end
      CLR: begin
        bus_wr_vo = 1'b1;
        addr_c    = ADDR_O_BASE;
      end
      START: begin
        bus_wr_vo = 1'b1;
        addr_c    = ADDR_START;
      end
      READ: begin
        if (rd_issue) addr_c = region_addr(ADDR_O_BASE, ridx);
      end
      default: ;
    endcase
  end

  // While reset is held every output reads 0, including the otherwise parked address.
  assign bus_addr_o = rst_i ? addr_c : 8'd0;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= IDLE;
      cnt       <= '0;
      ridx      <= '0;
      guard     <= '0;
      poll_cnt  <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      err_o     <= 1'b0;
      rd_vld_p1 <= 1'b0;
    end else begin
      done_o    <= 1'b0;
      rd_vld_p1 <= rd_issue;
      case (state)
        IDLE: begin
          if (start_i) begin
            state    <= LOAD_W;
            busy_o   <= 1'b1;
            err_o    <= 1'b0;
            cnt      <= '0;
            ridx     <= '0;
            guard    <= '0;
            poll_cnt <= '0;
          end
        end
        LOAD_W: begin
          if (src_hs) begin
            cnt <= cnt + 6'd1;
            if (cnt == 6'd63) state <= LOAD_X;
          end
        end
        LOAD_X: begin
          if (src_hs) begin
            cnt <= cnt + 6'd1;
            if (cnt == 6'd63) state <= CLR;
          end
        end
        CLR: state <= START;
        START: begin
          guard <= 8'(START_GUARD);
          state <= WAIT;
        end
        WAIT: begin
          // Leaves after START_GUARD idle cycles (at least one).
          if (guard != 8'd0) guard <= guard - 8'd1;
          if (guard <= 8'd1) state <= POLL;
        end
        POLL: begin
          if (bus_rdata_i[0]) begin
            state <= READ;
          end else if (poll_cnt == PW'(POLL_TIMEOUT - 1)) begin
            err_o  <= 1'b1;
            done_o <= 1'b1;
            busy_o <= 1'b0;
            state  <= IDLE;
          end else begin
            poll_cnt <= poll_cnt + 1'b1;
          end
        end
        READ: begin
          if (rd_issue) begin
            ridx <= ridx + 6'd1;
            if (ridx == 6'd63) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!rd_vld_p1 && (fifo_cnt == 2'd0)) begin
            done_o <= 1'b1;
            busy_o <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---- p1: read issued last cycle; bus_rdata_i now holds its data ----
  always_ff @(posedge clk_i) begin
    if (rd_issue) rd_idx_p1 <= ridx;
  end

  sa_res_fifo #(.W(FW)) u_res_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push      (rd_vld_p1),
    .push_data ({rd_idx_p1, bus_rdata_i}),
    .pop_rdy   (res_rdy_i),
    .q         (fifo_q),
    .vld       (fifo_vld),
    .count     (fifo_cnt)
  );

  assign res_v_o    = fifo_vld;
  assign res_idx_o  = fifo_q[FW-1 -: 6];
  assign res_data_o = fifo_q[RW-1:0];

endmodule

// File: tb/tb_sa_host_seq.sv
// tb_sa_host_seq: randomized self-checking bench for sa_host_seq.
// Two instances: dut (default poll timeout, bus model raising done 24 cycles
// after the start write) and dut_to (poll timeout 16, done never raised).
module tb_sa_host_seq;
  localparam int MAC_W = 19;
  localparam int X_W   = 8;
  localparam int RW    = MAC_W + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic start, start2, src_v, res_rdy;
  logic [X_W-1:0] src_data;

  logic busy, done, err, src_rdy, res_v, wr;
  logic [RW-1:0] res_data, rdata;
  logic [5:0] res_idx;
  logic [7:0] addr;
  logic [31:0] wdata;

  logic busy2, done2, err2, src_rdy2, res_v2, wr2;
  logic [RW-1:0] res_data2;
  logic [RW-1:0] rdata2 = '0;
  logic [5:0] res_idx2;
  logic [7:0] addr2;
  logic [31:0] wdata2;

  sa_host_seq #(.MAC_W(MAC_W), .X_W(X_W), .POLL_TIMEOUT(1024), .START_GUARD(2)) dut (
    .clk_i(clk), .rst_i(rst_n), .start_i(start), .busy_o(busy), .done_o(done), .err_o(err),
    .src_data_i(src_data), .src_v_i(src_v), .src_rdy_o(src_rdy),
    .res_data_o(res_data), .res_idx_o(res_idx), .res_v_o(res_v), .res_rdy_i(res_rdy),
    .bus_addr_o(addr), .bus_data_o(wdata), .bus_wr_vo(wr), .bus_rdata_i(rdata));

  sa_host_seq #(.MAC_W(MAC_W), .X_W(X_W), .POLL_TIMEOUT(16), .START_GUARD(2)) dut_to (
    .clk_i(clk), .rst_i(rst_n), .start_i(start2), .busy_o(busy2), .done_o(done2), .err_o(err2),
    .src_data_i(src_data), .src_v_i(src_v), .src_rdy_o(src_rdy2),
    .res_data_o(res_data2), .res_idx_o(res_idx2), .res_v_o(res_v2), .res_rdy_i(res_rdy),
    .bus_addr_o(addr2), .bus_data_o(wdata2), .bus_wr_vo(wr2), .bus_rdata_i(rdata2));

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Bus model: output buffer returns rd_base+offset; any other read returns
  // the done bit, high from done_delay cycles after the start write onward.
  int start_cyc = -1;
  int done_delay = 24;
  logic [RW-1:0] rd_base = RW'(1000);
  always @(posedge clk) begin
    if (!wr && addr >= 8'd128 && addr < 8'd192) rdata <= rd_base + RW'(addr - 8'd128);
    else if (!wr) rdata <= RW'(start_cyc >= 0 && (cyc + 1) >= (start_cyc + done_delay));
    else rdata <= '0;
  end

  typedef struct { int a; int d; int c; } ev_t;
  ev_t wq[$];
  ev_t rq[$];
  ev_t resq[$];
  int done_cyc[$];
  int done2_cyc[$];
  int park_bad, stall_bad, hold_bad, resv2_cnt;
  int start2_cyc = -1;
  logic prev_hold = 1'b0;
  logic [RW-1:0] prev_data;
  logic [5:0] prev_idx;

  function automatic ev_t mk(input int a, input int d, input int c);
    ev_t e;
    e.a = a; e.d = d; e.c = c;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (wr) begin
        wq.push_back(mk(int'(addr), int'(wdata), cyc));
        if (addr == 8'd128) start_cyc = -1;
        if (addr == 8'd192) start_cyc = cyc;
      end else if (addr >= 8'd128 && addr < 8'd192) begin
        rq.push_back(mk(int'(addr), 0, cyc));
      end else if (addr != 8'd192) begin
        park_bad++;
      end
      if (src_rdy && !src_v && wr) stall_bad++;
      if (prev_hold && !(res_v && res_data == prev_data && res_idx == prev_idx)) hold_bad++;
      prev_hold = res_v && !res_rdy;
      prev_data = res_data;
      prev_idx  = res_idx;
      if (res_v && res_rdy) resq.push_back(mk(int'(res_idx), int'(res_data), cyc));
      if (done) done_cyc.push_back(cyc);
      if (wr2 && addr2 == 8'd192) start2_cyc = cyc;
      if (res_v2) resv2_cnt++;
      if (done2) done2_cyc.push_back(cyc);
    end else begin
      prev_hold = 1'b0;
    end
  end

  int rmode = 0;
  initial forever begin
    @(posedge clk); #1;
    case (rmode)
      0:       res_rdy = 1'b1;
      1:       res_rdy = (cyc % 3 == 0);
      default: res_rdy = 1'($urandom_range(0, 1));
    endcase
  end

  logic [X_W-1:0] srcmem [128];

  // All task drives happen 1 time unit after a rising edge.
  task automatic pulse(input bit use2);
    if (use2) start2 = 1'b1; else start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; start2 = 1'b0;
  endtask

  task automatic load_src(input bit use2, input int vmode);
    int k = 0;
    int n = 0;
    bit hs;
    while (k < 128 && n < 2000) begin
      case (vmode)
        0:       src_v = 1'b1;
        1:       src_v = (n % 2 == 0);
        default: src_v = 1'($urandom_range(0, 1));
      endcase
      src_data = srcmem[k];
      @(negedge clk);
      hs = src_v && (use2 ? src_rdy2 : src_rdy);
      @(posedge clk); #1;
      if (hs) k++;
      n++;
    end
    src_v = 1'b0;
    check_eq("load_budget", k, 128);
  endtask

  task automatic check_job(input string nm, input bit contig);
    int nbad;
    int ea, ed;
    check_eq({nm, "_nwr"}, wq.size(), 130);
    nbad = 0;
    for (int i = 0; i < wq.size() && i < 130; i++) begin
      ea = (i < 128) ? i : ((i == 128) ? 128 : 192);
      ed = (i < 128) ? int'(srcmem[i]) : 0;
      if (wq[i].a != ea || wq[i].d != ed) nbad++;
    end
    check_eq({nm, "_wr_seq_bad"}, nbad, 0);
    if (wq.size() == 130) begin
      if (contig) check_eq({nm, "_wr_span"}, wq[129].c - wq[0].c, 129);
      check_eq({nm, "_clr_start_gap"}, wq[129].c - wq[127].c, 2);
      if (rq.size() > 0) check_eq({nm, "_first_rd"}, rq[0].c - wq[129].c, 25);
    end
    check_eq({nm, "_nrd"}, rq.size(), 64);
    nbad = 0;
    for (int i = 0; i < rq.size() && i < 64; i++) if (rq[i].a != 128 + i) nbad++;
    check_eq({nm, "_rd_seq_bad"}, nbad, 0);
    check_eq({nm, "_nres"}, resq.size(), 64);
    nbad = 0;
    for (int i = 0; i < resq.size() && i < 64; i++)
      if (resq[i].a != i || resq[i].d != int'(rd_base) + i) nbad++;
    check_eq({nm, "_res_bad"}, nbad, 0);
    check_eq({nm, "_ndone"}, done_cyc.size(), 1);
    if (done_cyc.size() > 0 && resq.size() > 0)
      check_eq({nm, "_done_after_res"}, done_cyc[0] > resq[resq.size()-1].c, 1);
    check_eq({nm, "_park_bad"}, park_bad, 0);
    check_eq({nm, "_stall_wr"}, stall_bad, 0);
    check_eq({nm, "_hold_bad"}, hold_bad, 0);
    check_eq({nm, "_busy_end"}, busy, 0);
    check_eq({nm, "_err_end"}, err, 0);
  endtask

  task automatic prep_job(input int vmode, input int rm);
    wq.delete(); rq.delete(); resq.delete(); done_cyc.delete();
    park_bad = 0; stall_bad = 0; hold_bad = 0;
    for (int i = 0; i < 128; i++) srcmem[i] = (vmode == 0) ? X_W'(i) : X_W'($urandom);
    rd_base = (rm == 1) ? RW'(1000) : RW'($urandom_range(0, 500000));
    rmode = rm;
  endtask

  task automatic main_job(input int vmode, input int rm, input string nm);
    int t = 0;
    prep_job(vmode, rm);
    pulse(0);
    load_src(0, vmode);
    pulse(0);  // lands while busy, must not restart the job
    while (done_cyc.size() == 0 && t < 3000) begin @(posedge clk); #1; t++; end
    check_eq({nm, "_done_seen"}, done_cyc.size() != 0, 1);
    repeat (3) @(posedge clk);
    #1;
    check_job(nm, vmode == 0);
  endtask

  task automatic check_zero(input string nm);
    check_eq({nm, "_busy"}, busy, 0);
    check_eq({nm, "_done"}, done, 0);
    check_eq({nm, "_err"}, err, 0);
    check_eq({nm, "_srdy"}, src_rdy, 0);
    check_eq({nm, "_resv"}, res_v, 0);
    check_eq({nm, "_resd"}, res_data, 0);
    check_eq({nm, "_resi"}, res_idx, 0);
    check_eq({nm, "_addr"}, addr, 0);
    check_eq({nm, "_wdata"}, wdata, 0);
    check_eq({nm, "_wr"}, wr, 0);
  endtask

  initial begin
    int t;
    start = 1'b0; start2 = 1'b0; src_v = 1'b0; src_data = '0;
    #1 rst_n = 1'b0;
    #3;
    check_zero("rst0");
    check_eq("rst0_to_busy", busy2, 0);
    check_eq("rst0_to_addr", addr2, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("idle_park", addr, 192);
    check_eq("idle_busy", busy, 0);

    main_job(0, 0, "ramp");
    main_job(1, 2, "stall");
    main_job(2, 1, "bp");

    // Reset in the middle of the result readout.
    prep_job(2, 1);
    pulse(0);
    load_src(0, 2);
    t = 0;
    while (resq.size() < 10 && t < 2000) begin @(posedge clk); #1; t++; end
    check_eq("midrst_reached", resq.size() >= 10, 1);
    #2 rst_n = 1'b0;
    #1;
    check_zero("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("midrst_idle_busy", busy, 0);
    check_eq("midrst_idle_park", addr, 192);
    main_job(2, 2, "post_rst");

    // Poll timeout on the short-timeout instance.
    done2_cyc.delete(); resv2_cnt = 0; start2_cyc = -1;
    for (int i = 0; i < 128; i++) srcmem[i] = X_W'($urandom);
    rmode = 0;
    pulse(1);
    load_src(1, 2);
    t = 0;
    while (done2_cyc.size() == 0 && t < 500) begin @(posedge clk); #1; t++; end
    check_eq("to_done_seen", done2_cyc.size() != 0, 1);
    if (done2_cyc.size() > 0) check_eq("to_done_cycle", done2_cyc[0] - start2_cyc, 19);
    check_eq("to_err", err2, 1);
    repeat (4) @(posedge clk);
    #1;
    check_eq("to_ndone", done2_cyc.size(), 1);
    check_eq("to_no_results", resv2_cnt, 0);
    check_eq("to_busy_end", busy2, 0);
    check_eq("to_err_sticky", err2, 1);
    check_eq("to_main_idle", busy, 0);
    pulse(1);
    check_eq("to_err_cleared", err2, 0);
    check_eq("to_restart_busy", busy2, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
